pipelined_alu_core: RTL and testbench

Parametrised successor of the team's two-stage MiniAlu CPU core: fetch/decode then execute, with write-back forwarding and zero-penalty branches. It adds parametrised data, register-address and IP widths, a multi-level CALL/RET stack with error detection, logic and shift ops, BEQ and HALT. It sits between the instruction ROM and the dual-read-port data RAM, both external. LED output is carried over; VGA/sprite ops stay in the top level.

---
 rtl/alu_core_pkg.sv | 48 ++++
 rtl/return_stack.sv | 51 +++++
 rtl/pipelined_alu_core.sv | 159 +++++++++++++++
 tb/tb_pipelined_alu_core.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_core_pkg.sv
// Shared definitions for pipelined_alu_core.
// Contents:
//   opcode_t        4-bit opcode enumeration (also serves as the operation type)
//   OP_W            opcode field width
//   opLsb/destLsb/src1Lsb  instruction field positions as functions of REG_AW
//                   (src0 always sits at bit 0)
//   writesRam       opcodes that drive the data-RAM write port
package alu_core_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_LED  = 4'd1,
        OP_STO  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_BLE  = 4'd10,
        OP_BEQ  = 4'd11,
        OP_JMP  = 4'd12,
        OP_CALL = 4'd13,
        OP_RET  = 4'd14,
        OP_HALT = 4'd15
    } opcode_t;

    // Instruction layout, MSB first: [op | dest | src1 | src0]
    function automatic int opLsb(int aw);
        return 3 * aw;
    endfunction

    function automatic int destLsb(int aw);
        return 2 * aw;
    endfunction

    function automatic int src1Lsb(int aw);
        return aw;
    endfunction

    function automatic logic writesRam(opcode_t op);
        return (op == OP_STO) || (op >= OP_ADD && op <= OP_SHR);
    endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO for CALL/RET.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears the pointer only)
//   push       write pushData on top (caller guarantees !full)
//   pop        drop the top entry (caller guarantees !empty)
//   pushData   return address to store
//   data       current top entry (valid when !empty)
//   full       DEPTH entries held
//   empty      no entries held
module return_stack #(
    parameter int IP_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [IP_W-1:0] pushData,
    output logic [IP_W-1:0] data,
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit so full and empty are distinguishable.
    logic [AW:0]     sp;
    logic [AW:0]     spDec;
    logic [IP_W-1:0] mem [DEPTH];

    assign spDec = sp - (AW+1)'(1);
    assign data  = mem[spDec[AW-1:0]];
    assign full  = (sp == (AW+1)'(DEPTH));
    assign empty = (sp == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       sp <= '0;
        else if (push) sp <= sp + (AW+1)'(1);
        else if (pop)  sp <= spDec;
    end

    // Storage needs no reset; the pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (push) mem[sp[AW-1:0]] <= pushData;
    end

    // A single instruction is either CALL or RET, never both.
    always @(posedge clk) begin
        if (!rst) assert (!(push && pop)) else $error("return_stack: push and pop in same cycle");
    end

endmodule

// File: rtl/pipelined_alu_core.sv
// Two-stage core: fetch/decode registers the ROM word, execute computes
// against synchronous-read RAM data with one-deep write-back forwarding.
// Branches redirect oIP combinationally, so the target is fetched in the
// same cycle (no bubble, no delay slot).
// Ports:
//   Clock, Reset             clock, asynchronous active-high reset
//   oIP / iInstruction       instruction ROM address / data (same cycle)
//   oReadAddr0/1, iReadData0/1  RAM read ports, data one cycle after address
//   oWriteEnable/Addr/Data   RAM write port, combinational from execute
//   oLed                     LED register
//   oHalted                  core halted (HALT executing or executed)
//   oStackErr                sticky CALL-overflow / RET-underflow flag
module pipelined_alu_core
    import alu_core_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 8,
    parameter int IP_W        = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    output logic [IP_W-1:0]         oIP,
    input  logic [OP_W+3*REG_AW-1:0] iInstruction,
    output logic [REG_AW-1:0]       oReadAddr0,
    output logic [REG_AW-1:0]       oReadAddr1,
    input  logic [DATA_W-1:0]       iReadData0,
    input  logic [DATA_W-1:0]       iReadData1,
    output logic                    oWriteEnable,
    output logic [REG_AW-1:0]       oWriteAddr,
    output logic [DATA_W-1:0]       oWriteData,
    output logic [7:0]              oLed,
    output logic                    oHalted,
    output logic                    oStackErr
);
    localparam int OP_LSB   = opLsb(REG_AW);
    localparam int DEST_LSB = destLsb(REG_AW);
    localparam int SRC1_LSB = src1Lsb(REG_AW);
    localparam int SHAMT_W  = $clog2(DATA_W);

    // Execute register
    opcode_t           rOp;
    logic [REG_AW-1:0] rDest, rSrc1, rSrc0;

    logic [IP_W-1:0]   rIP;
    logic              rHalted, rStackErr;
    logic [7:0]        rLed;

    // Previous cycle's write, covering the RAM read-before-write hazard
    logic              rFwdValid;
    logic [REG_AW-1:0] rFwdAddr;
    logic [DATA_W-1:0] rFwdData;

    logic [DATA_W-1:0]   opA, opB, result;
    logic [2*REG_AW-1:0] imm;
    logic [IP_W-1:0]     target, stackTop;
    logic                taken, halting;
    logic                stackFull, stackEmpty, doPush, doPop, stackFault;

    assign oReadAddr0 = iInstruction[0 +: REG_AW];
    assign oReadAddr1 = iInstruction[SRC1_LSB +: REG_AW];

    assign opA = (rFwdValid && rFwdAddr == rSrc1) ? rFwdData : iReadData1;
    assign opB = (rFwdValid && rFwdAddr == rSrc0) ? rFwdData : iReadData0;
    assign imm = {rSrc1, rSrc0};

    always_comb begin
        result = '0;
        case (rOp)
            OP_STO: result = DATA_W'(imm);
            OP_ADD: result = opA + opB;
            OP_SUB: result = opA - opB;
            OP_AND: result = opA & opB;
            OP_OR:  result = opA | opB;
            OP_XOR: result = opA ^ opB;
            OP_SHL: result = opA << opB[SHAMT_W-1:0];
            OP_SHR: result = opA >> opB[SHAMT_W-1:0];
            default: result = '0;
        endcase
    end

    assign oWriteEnable = writesRam(rOp);
    assign oWriteAddr   = rDest;
    assign oWriteData   = result;

    // Control flow
    assign target     = IP_W'(rDest);
    assign doPush     = (rOp == OP_CALL) && !stackFull;
    assign doPop      = (rOp == OP_RET) && !stackEmpty;
    assign stackFault = ((rOp == OP_CALL) && stackFull) || ((rOp == OP_RET) && stackEmpty);
    assign halting    = rHalted || (rOp == OP_HALT);

    always_comb begin
        taken = 1'b0;
        case (rOp)
            OP_JMP:  taken = 1'b1;
            OP_BLE:  taken = (opA <= opB);
            OP_BEQ:  taken = (opA == opB);
            OP_CALL: taken = doPush;
            default: taken = 1'b0;
        endcase
    end

    assign oIP = taken ? target : (doPop ? stackTop : rIP);

    return_stack #(
        .IP_W (IP_W),
        .DEPTH(STACK_DEPTH)
    ) uStack (
        .clk     (Clock),
        .rst     (Reset),
        .push    (doPush),
        .pop     (doPop),
        .pushData(rIP),
        .data    (stackTop),
        .full    (stackFull),
        .empty   (stackEmpty)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rIP       <= '0;
            rOp       <= OP_NOP;
            rDest     <= '0;
            rSrc1     <= '0;
            rSrc0     <= '0;
            rHalted   <= 1'b0;
            rStackErr <= 1'b0;
            rLed      <= '0;
            rFwdValid <= 1'b0;
            rFwdAddr  <= '0;
            rFwdData  <= '0;
        end else begin
            rIP <= halting ? oIP : oIP + IP_W'(1);
            if (halting) begin
                rOp   <= OP_NOP;
                rDest <= '0;
                rSrc1 <= '0;
                rSrc0 <= '0;
            end else begin
                rOp   <= opcode_t'(iInstruction[OP_LSB +: OP_W]);
                rDest <= iInstruction[DEST_LSB +: REG_AW];
                rSrc1 <= iInstruction[SRC1_LSB +: REG_AW];
                rSrc0 <= iInstruction[0 +: REG_AW];
            end
            rHalted <= halting;
            if (stackFault)     rStackErr <= 1'b1;
            if (rOp == OP_LED)  rLed      <= opA[7:0];
            rFwdValid <= oWriteEnable;
            rFwdAddr  <= oWriteAddr;
            rFwdData  <= oWriteData;
        end
    end

    assign oLed      = rLed;
    assign oHalted   = halting;
    assign oStackErr = rStackErr;

endmodule

// File: tb/tb_pipelined_alu_core.sv
module tb_pipelined_alu_core;
    import alu_core_pkg::*;

    logic        Clock;
    logic        Reset;
    logic [15:0] oIP;
    logic [27:0] iInstruction;
    logic [7:0]  oReadAddr0, oReadAddr1;
    logic [15:0] iReadData0, iReadData1;
    logic        oWriteEnable;
    logic [7:0]  oWriteAddr;
    logic [15:0] oWriteData;
    logic [7:0]  oLed;
    logic        oHalted, oStackErr;

    int checks = 0;
    int errors = 0;

    logic [27:0] rom [65536];
    logic [15:0] ram [256] = '{default: '0};

    pipelined_alu_core dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .oIP         (oIP),
        .iInstruction(iInstruction),
        .oReadAddr0  (oReadAddr0),
        .oReadAddr1  (oReadAddr1),
        .iReadData0  (iReadData0),
        .iReadData1  (iReadData1),
        .oWriteEnable(oWriteEnable),
        .oWriteAddr  (oWriteAddr),
        .oWriteData  (oWriteData),
        .oLed        (oLed),
        .oHalted     (oHalted),
        .oStackErr   (oStackErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign iInstruction = rom[oIP];

    // Synchronous-read RAM, read-before-write on the same edge
    always @(posedge Clock) begin
        iReadData0 <= ram[oReadAddr0];
        iReadData1 <= ram[oReadAddr1];
        if (oWriteEnable) ram[oWriteAddr] <= oWriteData;
    end

    function automatic logic [27:0] mk(logic [3:0] op, logic [7:0] d, logic [7:0] s1, logic [7:0] s0);
        return {op, d, s1, s0};
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 65536; i++) rom[i] = '0;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clock);
    endtask

    initial begin
        // ---------------- Program A: forwarding, BLE, ALU ops ----------------
        Reset = 1'b1;
        clearRom();
        rom[16'h00] = mk(OP_STO, 8'd1, 8'h00, 8'h05);
        rom[16'h01] = mk(OP_ADD, 8'd2, 8'd1, 8'd1);
        rom[16'h02] = mk(OP_STO, 8'd1, 8'h00, 8'h03);
        rom[16'h03] = mk(OP_STO, 8'd2, 8'h00, 8'h07);
        rom[16'h04] = mk(OP_BLE, 8'h20, 8'd1, 8'd2);
        rom[16'h05] = mk(OP_STO, 8'd9, 8'h00, 8'hAB);
        rom[16'h21] = mk(OP_STO, 8'd1, 8'h00, 8'hF0);
        rom[16'h22] = mk(OP_STO, 8'd2, 8'h00, 8'h04);
        rom[16'h23] = mk(OP_SHL, 8'd3, 8'd1, 8'd2);
        rom[16'h24] = mk(OP_XOR, 8'd4, 8'd1, 8'd1);
        rom[16'h25] = mk(OP_LED, 8'd0, 8'd1, 8'd0);
        rom[16'h26] = mk(OP_SUB, 8'd5, 8'd2, 8'd1);
        rom[16'h27] = mk(OP_OR,  8'd6, 8'd1, 8'd3);
        rom[16'h28] = mk(OP_AND, 8'd7, 8'd5, 8'd1);
        rom[16'h29] = mk(OP_SHR, 8'd8, 8'd3, 8'd2);
        rom[16'h2A] = mk(OP_BLE, 8'h50, 8'd3, 8'd1);
        rom[16'h2B] = mk(OP_BEQ, 8'h50, 8'd1, 8'd2);
        rom[16'h2C] = mk(OP_BEQ, 8'h40, 8'd1, 8'd1);
        rom[16'h40] = mk(OP_STO, 8'd9, 8'h00, 8'h77);
        repeat (2) cyc();
        check("rst.ip",     32'(oIP), 32'h0);
        check("rst.we",     32'(oWriteEnable), 32'h0);
        check("rst.led",    32'(oLed), 32'h0);
        check("rst.halted", 32'(oHalted), 32'h0);
        check("rst.stkerr", 32'(oStackErr), 32'h0);
        Reset = 1'b0;
        check("A.c0.ip", 32'(oIP), 32'h0);
        cyc();
        check("A.sto.we",   32'(oWriteEnable), 32'h1);
        check("A.sto.addr", 32'(oWriteAddr), 32'h1);
        check("A.sto.data", 32'(oWriteData), 32'h5);
        cyc();
        check("A.fwd.addr", 32'(oWriteAddr), 32'h2);
        check("A.fwd.data", 32'(oWriteData), 32'd10);
        repeat (3) cyc();
        check("A.ble.ip", 32'(oIP), 32'h20);
        check("A.ble.we", 32'(oWriteEnable), 32'h0);
        cyc();
        check("A.shadow.we", 32'(oWriteEnable), 32'h0);
        check("A.shadow.ip", 32'(oIP), 32'h21);
        cyc();
        check("A.sto16.data", 32'(oWriteData), 32'h00F0);
        repeat (2) cyc();
        check("A.shl.addr", 32'(oWriteAddr), 32'h3);
        check("A.shl.data", 32'(oWriteData), 32'h0F00);
        cyc();
        check("A.xor.we",   32'(oWriteEnable), 32'h1);
        check("A.xor.data", 32'(oWriteData), 32'h0);
        cyc();
        check("A.led.we", 32'(oWriteEnable), 32'h0);
        cyc();
        check("A.led.val",  32'(oLed), 32'hF0);
        check("A.sub.data", 32'(oWriteData), 32'hFF14);
        cyc();
        check("A.or.data",  32'(oWriteData), 32'h0FF0);
        cyc();
        check("A.and.data", 32'(oWriteData), 32'h0010);
        cyc();
        check("A.shr.data", 32'(oWriteData), 32'h00F0);
        cyc();
        check("A.ble.nt.ip", 32'(oIP), 32'h2B);
        cyc();
        check("A.beq.nt.ip", 32'(oIP), 32'h2C);
        cyc();
        check("A.beq.ip", 32'(oIP), 32'h40);
        cyc();
        check("A.pend.we", 32'(oWriteEnable), 32'h1);
        // Asynchronous reset mid-cycle with a write pending
        #2 Reset = 1'b1;
        #1;
        check("async.we",  32'(oWriteEnable), 32'h0);
        check("async.ip",  32'(oIP), 32'h0);
        check("async.led", 32'(oLed), 32'h0);

        // ---------------- Program C: RET underflow, HALT ----------------
        clearRom();
        rom[16'h00] = mk(OP_RET, 8'h00, 8'h00, 8'h00);
        rom[16'h06] = mk(OP_HALT, 8'h00, 8'h00, 8'h00);
        rom[16'h07] = mk(OP_STO, 8'd1, 8'h00, 8'h55);
        cyc();
        Reset = 1'b0;
        check("C.c0.ip", 32'(oIP), 32'h0);
        cyc();
        check("C.ret.ip",     32'(oIP), 32'h1);
        check("C.ret.stkerr", 32'(oStackErr), 32'h0);
        cyc();
        check("C.underflow.stkerr", 32'(oStackErr), 32'h1);
        check("C.underflow.ip",     32'(oIP), 32'h2);
        repeat (5) cyc();
        check("C.halt.ip",     32'(oIP), 32'h7);
        check("C.halt.halted", 32'(oHalted), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("C.hold.ip",     32'(oIP), 32'h7);
            check("C.hold.halted", 32'(oHalted), 32'h1);
            check("C.hold.we",     32'(oWriteEnable), 32'h0);
        end

        // ---------------- Program B: nested CALL/RET, overflow ----------------
        Reset = 1'b1;
        clearRom();
        rom[16'h01] = mk(OP_CALL, 8'h10, 8'h00, 8'h00);
        rom[16'h11] = mk(OP_CALL, 8'h20, 8'h00, 8'h00);
        rom[16'h21] = mk(OP_CALL, 8'h30, 8'h00, 8'h00);
        rom[16'h31] = mk(OP_CALL, 8'h40, 8'h00, 8'h00);
        rom[16'h40] = mk(OP_RET,  8'h00, 8'h00, 8'h00);
        rom[16'h32] = mk(OP_RET,  8'h00, 8'h00, 8'h00);
        rom[16'h22] = mk(OP_RET,  8'h00, 8'h00, 8'h00);
        rom[16'h12] = mk(OP_RET,  8'h00, 8'h00, 8'h00);
        rom[16'h02] = mk(OP_CALL, 8'h60, 8'h00, 8'h00);
        rom[16'h60] = mk(OP_CALL, 8'h70, 8'h00, 8'h00);
        rom[16'h70] = mk(OP_CALL, 8'h80, 8'h00, 8'h00);
        rom[16'h80] = mk(OP_CALL, 8'h90, 8'h00, 8'h00);
        rom[16'h90] = mk(OP_CALL, 8'hA0, 8'h00, 8'h00);
        rom[16'h91] = mk(OP_RET,  8'h00, 8'h00, 8'h00);
        cyc();
        check("B.rst.halted", 32'(oHalted), 32'h0);
        check("B.rst.stkerr", 32'(oStackErr), 32'h0);
        Reset = 1'b0;
        check("B.c0.ip", 32'(oIP), 32'h0);
        cyc();
        check("B.c1.ip", 32'(oIP), 32'h1);
        cyc();
        check("B.call1.ip", 32'(oIP), 32'h10);
        repeat (2) cyc();
        check("B.call2.ip", 32'(oIP), 32'h20);
        repeat (2) cyc();
        check("B.call3.ip", 32'(oIP), 32'h30);
        repeat (2) cyc();
        check("B.call4.ip", 32'(oIP), 32'h40);
        cyc();
        check("B.ret1.ip", 32'(oIP), 32'h32);
        cyc();
        check("B.ret2.ip", 32'(oIP), 32'h22);
        cyc();
        check("B.ret3.ip", 32'(oIP), 32'h12);
        cyc();
        check("B.ret4.ip",     32'(oIP), 32'h02);
        check("B.nest.stkerr", 32'(oStackErr), 32'h0);
        cyc();
        check("B.fill1.ip", 32'(oIP), 32'h60);
        cyc();
        check("B.fill2.ip", 32'(oIP), 32'h70);
        cyc();
        check("B.fill3.ip", 32'(oIP), 32'h80);
        cyc();
        check("B.fill4.ip",     32'(oIP), 32'h90);
        check("B.fill4.stkerr", 32'(oStackErr), 32'h0);
        cyc();
        check("B.ovf.ip", 32'(oIP), 32'h91);
        cyc();
        check("B.ovf.stkerr", 32'(oStackErr), 32'h1);
        check("B.ovf.ret.ip", 32'(oIP), 32'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
